n4fpga_pwm_meas_sched: RTL and testbench

Round-robin measurement scheduler for the RGB PWM outputs. It shares one high/low period measurement engine across NUM_CH PWM inputs. For each channel it selects the input, lets it settle, then captures one complete high period and the following low period. It presents each result through a valid/ready handshake to the AXI GPIO/register side and recovers from stuck (0% or 100% duty) inputs by timeout.

---
 rtl/n4fpga_pwm_meas_sched_if.sv | 26 ++
 rtl/n4fpga_pwm_meas_sched.sv | 195 +++++++++++++++++++
 tb/tb_n4fpga_pwm_meas_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/n4fpga_pwm_meas_sched_if.sv
// Result handshake between the PWM measurement scheduler (master) and the
// register-side consumer (slave).
interface n4fpga_pwm_meas_sched_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             result_valid;
    logic             result_ready;
    logic [CH_W-1:0]  result_ch;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] low_count;
    logic             timeout;
    logic             stuck_level;

    modport master (
        output result_valid, result_ch, high_count, low_count, timeout, stuck_level,
        input  result_ready
    );

    modport slave (
        input  result_valid, result_ch, high_count, low_count, timeout, stuck_level,
        output result_ready
    );
endinterface

// File: rtl/n4fpga_pwm_meas_sched.sv
// Round-robin high/low period measurement of NUM_CH PWM inputs through one
// shared engine, with timeout recovery for inputs stuck at 0% or 100% duty.
module n4fpga_pwm_meas_sched #(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 32,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                      clock_3,
    input  logic                      Reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         pwm_in,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      busy,
    n4fpga_pwm_meas_sched_if.master   res
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] TMO         = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        WAIT_RISE = 3'd2,
        MEAS_HIGH = 3'd3,
        MEAS_LOW  = 3'd4,
        PRESENT   = 3'd5
    } state_t;

    state_t           state_r, state_nx;
    logic [CH_W-1:0]  ch_sel_r, ch_nx, rch_r, rch_nx;
    logic [CNT_W-1:0] scnt_r, scnt_nx, pcnt_r, pcnt_nx, tcnt_r, tcnt_nx;
    logic [CNT_W-1:0] hi_r, hi_nx, lo_r, lo_nx;
    logic             to_r, to_nx, stuck_r, stuck_nx;
    logic             valid_r, busy_r;
    logic             meta_r, s_r, prev_r;
    logic             rise_s, fall_s, tmo_hit_s;
    logic [2*CNT_W+CH_W:0] tmo_pack_s;

    // Two-flop synchronizer on the selected input plus one cycle of history.
    always_ff @(posedge clock_3) begin
        if (Reset) begin
            meta_r <= 1'b0;
            s_r    <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= pwm_in[ch_sel_r];
            s_r    <= meta_r;
            prev_r <= s_r;
        end
    end

    assign rise_s    = s_r & ~prev_r;
    assign fall_s    = ~s_r & prev_r;
    assign tmo_hit_s = (tcnt_r >= TMO_LAST);
    // Stuck result: the whole timeout window lands in the period matching the level.
    assign tmo_pack_s = {(s_r ? TMO : {CNT_W{1'b0}}), (s_r ? {CNT_W{1'b0}} : TMO), s_r, ch_sel_r};

    // FSM state register.
    always_ff @(posedge clock_3) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and datapath update; the expected edge is tested before the timeout.
    always_comb begin
        state_nx = state_r;
        ch_nx    = ch_sel_r;
        scnt_nx  = scnt_r;
        pcnt_nx  = pcnt_r;
        tcnt_nx  = tcnt_r;
        hi_nx    = hi_r;
        lo_nx    = lo_r;
        rch_nx   = rch_r;
        to_nx    = to_r;
        stuck_nx = stuck_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nx = SETTLE;
                    scnt_nx  = {CNT_W{1'b0}};
                end else begin
                    state_nx = IDLE;
                end
            end
            SETTLE: begin
                if (scnt_r >= SETTLE_LAST) begin
                    state_nx = WAIT_RISE;
                    tcnt_nx  = {CNT_W{1'b0}};
                end else begin
                    scnt_nx = scnt_r + CNT_W'(1);
                end
            end
            WAIT_RISE: begin
                if (rise_s) begin
                    state_nx = MEAS_HIGH;
                    pcnt_nx  = CNT_W'(1);
                    tcnt_nx  = {CNT_W{1'b0}};
                end else if (tmo_hit_s) begin
                    state_nx = PRESENT;
                    to_nx    = 1'b1;
                    {hi_nx, lo_nx, stuck_nx, rch_nx} = tmo_pack_s;
                end else begin
                    tcnt_nx = tcnt_r + CNT_W'(1);
                end
            end
            MEAS_HIGH: begin
                if (fall_s) begin
                    state_nx = MEAS_LOW;
                    hi_nx    = pcnt_r;
                    pcnt_nx  = CNT_W'(1);
                    tcnt_nx  = {CNT_W{1'b0}};
                end else if (tmo_hit_s) begin
                    state_nx = PRESENT;
                    to_nx    = 1'b1;
                    {hi_nx, lo_nx, stuck_nx, rch_nx} = tmo_pack_s;
                end else begin
                    tcnt_nx = tcnt_r + CNT_W'(1);
                    pcnt_nx = (s_r && (pcnt_r < TMO)) ? pcnt_r + CNT_W'(1) : pcnt_r;
                end
            end
            MEAS_LOW: begin
                if (rise_s) begin
                    state_nx = PRESENT;
                    lo_nx    = pcnt_r;
                    to_nx    = 1'b0;
                    stuck_nx = 1'b0;
                    rch_nx   = ch_sel_r;
                end else if (tmo_hit_s) begin
                    state_nx = PRESENT;
                    to_nx    = 1'b1;
                    {hi_nx, lo_nx, stuck_nx, rch_nx} = tmo_pack_s;
                end else begin
                    tcnt_nx = tcnt_r + CNT_W'(1);
                    pcnt_nx = (!s_r && (pcnt_r < TMO)) ? pcnt_r + CNT_W'(1) : pcnt_r;
                end
            end
            PRESENT: begin
                if (res.result_ready) begin
                    ch_nx    = (ch_sel_r == LAST_CH) ? {CH_W{1'b0}} : ch_sel_r + CH_W'(1);
                    state_nx = enable ? SETTLE : IDLE;
                    scnt_nx  = {CNT_W{1'b0}};
                end else begin
                    state_nx = PRESENT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; valid/busy follow the state being entered.
    always_ff @(posedge clock_3) begin
        if (Reset) begin
            ch_sel_r <= {CH_W{1'b0}};
            rch_r    <= {CH_W{1'b0}};
            scnt_r   <= {CNT_W{1'b0}};
            pcnt_r   <= {CNT_W{1'b0}};
            tcnt_r   <= {CNT_W{1'b0}};
            hi_r     <= {CNT_W{1'b0}};
            lo_r     <= {CNT_W{1'b0}};
            to_r     <= 1'b0;
            stuck_r  <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            ch_sel_r <= ch_nx;
            rch_r    <= rch_nx;
            scnt_r   <= scnt_nx;
            pcnt_r   <= pcnt_nx;
            tcnt_r   <= tcnt_nx;
            hi_r     <= hi_nx;
            lo_r     <= lo_nx;
            to_r     <= to_nx;
            stuck_r  <= stuck_nx;
            valid_r  <= (state_nx == PRESENT);
            busy_r   <= (state_nx != IDLE);
        end
    end

    assign ch_sel           = ch_sel_r;
    assign busy             = busy_r;
    assign res.result_valid = valid_r;
    assign res.result_ch    = rch_r;
    assign res.high_count   = hi_r;
    assign res.low_count    = lo_r;
    assign res.timeout      = to_r;
    assign res.stuck_level  = stuck_r;
endmodule

// File: tb/tb_n4fpga_pwm_meas_sched.sv
// Directed bench for the PWM measurement scheduler: periodic, stuck, back-pressure,
// reset-abort and enable-drop scenarios with hand-computed period counts.
module tb_n4fpga_pwm_meas_sched;
    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 32;
    localparam int SETTLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 128;

    logic       clock_3 = 1'b0;
    logic       Reset   = 1'b1;
    logic       enable  = 1'b0;
    logic [2:0] pwm_in  = 3'b000;
    logic [1:0] ch_sel;
    logic       busy;

    n4fpga_pwm_meas_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) res_if ();

    n4fpga_pwm_meas_sched #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock_3(clock_3),
        .Reset  (Reset),
        .enable (enable),
        .pwm_in (pwm_in),
        .ch_sel (ch_sel),
        .busy   (busy),
        .res    (res_if)
    );

    always #5 clock_3 = ~clock_3;

    // mode 0 = periodic hi/lo, 1 = held high, 2 = held low
    int hi_len[3] = '{30, 20, 5};
    int lo_len[3] = '{70, 20, 95};
    int mode[3]   = '{0, 0, 0};
    int phase[3]  = '{0, 0, 0};
    int n_vec = 0;
    int n_bad = 0;

    // PWM sources change away from the sampling edge.
    always @(negedge clock_3) begin
        for (int i = 0; i < 3; i++) begin
            if (mode[i] == 1) begin
                pwm_in[i] = 1'b1;
            end else if (mode[i] == 2) begin
                pwm_in[i] = 1'b0;
            end else begin
                phase[i]  = (phase[i] + 1 >= hi_len[i] + lo_len[i]) ? 0 : phase[i] + 1;
                pwm_in[i] = (phase[i] < hi_len[i]);
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clock_3);
        while (res_if.result_valid !== 1'b1 && n < 3000) begin
            @(negedge clock_3);
            n++;
        end
        check_val({tag, "_valid"}, 64'(res_if.result_valid), 64'd1);
    endtask

    task automatic wait_state(input int st, input int ch);
        int n = 0;
        while (!(int'(dut.state_r) == st && int'(ch_sel) == ch) && n < 3000) begin
            @(negedge clock_3);
            n++;
        end
        check_val("reach_state", 64'(int'(dut.state_r)), 64'(st));
    endtask

    task automatic check_fields(input string tag, input int ch, input int hi, input int lo,
                                input int to, input int st);
        check_val({tag, "_ch"},    64'(res_if.result_ch),   64'(ch));
        check_val({tag, "_high"},  64'(res_if.high_count),  64'(hi));
        check_val({tag, "_low"},   64'(res_if.low_count),   64'(lo));
        check_val({tag, "_tmo"},   64'(res_if.timeout),     64'(to));
        check_val({tag, "_stuck"}, 64'(res_if.stuck_level), 64'(st));
    endtask

    // Expects one result with ready held high, then checks valid drop and channel advance.
    task automatic expect_result(input string tag, input int ch, input int hi, input int lo,
                                 input int to, input int st);
        wait_valid(tag);
        check_fields(tag, ch, hi, lo, to, st);
        @(negedge clock_3);
        check_val({tag, "_vdrop"}, 64'(res_if.result_valid), 64'd0);
        check_val({tag, "_next"},  64'(ch_sel), 64'((ch + 1) % 3));
    endtask

    initial begin
        int changes;
        res_if.result_ready = 1'b1;
        repeat (3) @(negedge clock_3);
        check_val("rst_valid", 64'(res_if.result_valid), 64'd0);
        check_val("rst_busy",  64'(busy), 64'd0);
        check_val("rst_chsel", 64'(ch_sel), 64'd0);
        check_val("rst_high",  64'(res_if.high_count), 64'd0);
        Reset  = 1'b0;
        enable = 1'b1;

        // Basic and round-robin measurements, ch_sel wraps 2 -> 0.
        expect_result("r1_ch0", 0, 30, 70, 0, 0);
        expect_result("r2_ch1", 1, 20, 20, 0, 0);
        expect_result("r3_ch2", 2, 5, 95, 0, 0);
        mode[1] = 1;
        expect_result("r4_ch0", 0, 30, 70, 0, 0);
        // Stuck inputs recovered by timeout.
        expect_result("r5_ch1hi", 1, TIMEOUT_CYC, 0, 1, 1);
        expect_result("r6_ch2", 2, 5, 95, 0, 0);
        mode[1] = 2;
        expect_result("r7_ch0", 0, 30, 70, 0, 0);
        expect_result("r8_ch1lo", 1, 0, TIMEOUT_CYC, 1, 0);
        mode[1] = 0;

        // Back-pressure: 50 cycles without ready.
        res_if.result_ready = 1'b0;
        wait_valid("bp");
        check_fields("bp", 2, 5, 95, 0, 0);
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock_3);
            if (res_if.result_valid !== 1'b1 || res_if.high_count !== 32'd5 ||
                res_if.low_count !== 32'd95 || res_if.result_ch !== 2'd2 ||
                res_if.timeout !== 1'b0 || ch_sel !== 2'd2) changes++;
        end
        check_val("bp_hold_changes", 64'(changes), 64'd0);
        res_if.result_ready = 1'b1;
        @(negedge clock_3);
        check_val("bp_vdrop", 64'(res_if.result_valid), 64'd0);
        check_val("bp_next",  64'(ch_sel), 64'd0);

        // Reset pulse in MEAS_HIGH aborts without a partial result.
        wait_state(3, 0);
        Reset = 1'b1;
        @(negedge clock_3);
        Reset = 1'b0;
        check_val("mid_rst_valid", 64'(res_if.result_valid), 64'd0);
        check_val("mid_rst_busy",  64'(busy), 64'd0);
        check_val("mid_rst_chsel", 64'(ch_sel), 64'd0);
        check_val("mid_rst_high",  64'(res_if.high_count), 64'd0);
        check_val("mid_rst_low",   64'(res_if.low_count), 64'd0);
        expect_result("r9_ch0", 0, 30, 70, 0, 0);

        // Enable dropped in MEAS_LOW of ch1: ch1 completes, then idle at ch2.
        wait_state(4, 1);
        enable = 1'b0;
        expect_result("r10_ch1", 1, 20, 20, 0, 0);
        check_val("idle_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clock_3);
        check_val("idle_busy_hold", 64'(busy), 64'd0);
        check_val("idle_chsel", 64'(ch_sel), 64'd2);
        hi_len[2] = 1;
        lo_len[2] = 9;
        enable = 1'b1;
        expect_result("r11_ch2pulse", 2, 1, 9, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
